// File: rtl/remap_pkg.sv
// remap_pkg: shared state type and default parameters for lut_remap_engine.
// FILL_D is only consumed when REMAP_OOB_EN is defined.
package remap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REMAP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIX_W_D       = 8;
    localparam int CH_D          = 1;
    localparam int ADDR_W_D      = 19;
    localparam int SRAM_RD_LAT_D = 2;
    localparam int OFIFO_DEPTH_D = 8;
    localparam int FILL_D        = 0;

endpackage

// File: rtl/remap_out_fifo.sv
// remap_out_fifo: show-ahead sync FIFO carrying {last,pixel} with occupancy count.
// The caller never pops when empty nor pushes when full.
module remap_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_rd,
    output logic [W-1:0]               o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_wp_nx;
    logic [AW-1:0] w_rp_nx;

    assign w_wp_nx = (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + AW'(1);
    assign w_rp_nx = (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + AW'(1);

    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wp] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr) r_wp <= w_wp_nx;
            if (i_rd) r_rp <= w_rp_nx;
            unique case ({i_wr, i_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/lut_remap_engine.sv
// lut_remap_engine: buffers a frame, stores a location LUT in SRAM, streams out[i] = frame[LUT[i]].
// Define REMAP_OOB_EN to substitute FILL for locations >= npix and raise sticky oob_err.
module lut_remap_engine
    import remap_pkg::*;
#(
    parameter int PIX_W       = PIX_W_D,
    parameter int CH          = CH_D,
    parameter int ADDR_W      = ADDR_W_D,
    parameter int SRAM_RD_LAT = SRAM_RD_LAT_D,
    parameter int OFIFO_DEPTH = OFIFO_DEPTH_D
`ifdef REMAP_OOB_EN
    ,
    parameter logic [CH*PIX_W-1:0] FILL = (CH*PIX_W)'(FILL_D)
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W:0]     cfg_npix,
    input  logic                frm_valid,
    input  logic [CH*PIX_W-1:0] frm_data,
    output logic                frm_ready,
    input  logic                lut_valid,
    input  logic [ADDR_W-1:0]   lut_data,
    output logic                lut_ready,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CH*PIX_W-1:0] m_data,
    output logic                m_last,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we_n,
    output logic [ADDR_W-1:0]   sram_wdata,
    input  logic [ADDR_W-1:0]   sram_rdata
`ifdef REMAP_OOB_EN
    ,
    output logic                oob_err
`endif
);

    localparam int PW = CH * PIX_W;
    localparam int L  = SRAM_RD_LAT;
    localparam int CW = $clog2(OFIFO_DEPTH + 1);

    if (SRAM_RD_LAT < 1 || OFIFO_DEPTH < SRAM_RD_LAT + 2) begin : g_bad_cfg
        $error("OFIFO_DEPTH must be >= SRAM_RD_LAT+2 and SRAM_RD_LAT >= 1");
    end

    state_t            r_state;
    logic [ADDR_W:0]   r_npix;
    logic [ADDR_W:0]   r_rcnt;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_lcnt;
    logic [CW-1:0]     r_infl;
    logic [L:0]        r_vp;
    logic [L:0]        r_lp;
    logic              r_rv;
    logic              r_rl;
    logic [PW-1:0]     r_rdat;
    logic              r_done;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_sram_we_n;
    logic [ADDR_W-1:0] r_sram_wd;
    logic [PW-1:0]     r_fram [2**ADDR_W];

    logic              w_idle;
    logic              w_frm_acc;
    logic              w_lut_acc;
    logic [ADDR_W:0]   w_wnext;
    logic [ADDR_W:0]   w_lnext;
    logic [CW-1:0]     w_fcnt;
    logic              w_empty;
    logic [PW:0]       w_head;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_pop;
    logic [PW-1:0]     w_fdata;

    assign w_idle    = (r_state == IDLE);
    assign w_frm_acc = frm_valid & w_idle;
    assign w_lut_acc = lut_valid & w_idle;
    assign w_wnext   = {1'b0, r_wcnt} + (ADDR_W+1)'(1);
    assign w_lnext   = {1'b0, r_lcnt} + (ADDR_W+1)'(1);

    // Credit rule: reads in flight plus FIFO occupancy never exceed FIFO depth.
    assign w_issue = (r_state == REMAP) && (r_rcnt != r_npix) &&
                     ((int'(r_infl) + int'(w_fcnt)) < OFIFO_DEPTH);
    assign w_issue_last = w_issue && (r_rcnt + (ADDR_W+1)'(1) == r_npix);
    assign w_pop = !w_empty && m_ready;

    always_ff @(posedge clk) begin
        if (w_frm_acc) r_fram[r_wcnt] <= frm_data;
        r_rdat <= r_fram[sram_rdata];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_npix      <= '0;
            r_rcnt      <= '0;
            r_wcnt      <= '0;
            r_lcnt      <= '0;
            r_infl      <= '0;
            r_vp        <= '0;
            r_lp        <= '0;
            r_rv        <= 1'b0;
            r_rl        <= 1'b0;
            r_done      <= 1'b0;
            r_sram_addr <= '0;
            r_sram_we_n <= 1'b1;
            r_sram_wd   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_sram_we_n <= 1'b1;
            r_vp        <= {r_vp[L-1:0], w_issue};
            r_lp        <= {r_lp[L-1:0], w_issue_last};
            r_rv        <= r_vp[L];
            r_rl        <= r_lp[L];
            if (w_issue && !r_rv) r_infl <= r_infl + CW'(1);
            else if (!w_issue && r_rv) r_infl <= r_infl - CW'(1);
            unique case (r_state)
                IDLE: begin
                    if (w_frm_acc)
                        r_wcnt <= (w_wnext == cfg_npix) ? '0 : w_wnext[ADDR_W-1:0];
                    if (w_lut_acc) begin
                        r_sram_addr <= r_lcnt;
                        r_sram_we_n <= 1'b0;
                        r_sram_wd   <= lut_data;
                        r_lcnt <= (w_lnext == cfg_npix) ? '0 : w_lnext[ADDR_W-1:0];
                    end
                    if (start) begin
                        r_npix  <= cfg_npix;
                        r_wcnt  <= '0;
                        r_lcnt  <= '0;
                        r_rcnt  <= '0;
                        r_state <= (cfg_npix == '0) ? DRAIN : REMAP;
                    end
                end
                REMAP: begin
                    if (w_issue) begin
                        r_sram_addr <= r_rcnt[ADDR_W-1:0];
                        r_rcnt      <= r_rcnt + (ADDR_W+1)'(1);
                    end
                    if (r_rcnt == r_npix) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (r_npix == '0 || (w_pop && w_head[PW])) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef REMAP_OOB_EN
    logic r_ro;
    logic r_oob;
    logic w_oob;

    assign w_oob = r_vp[L] && ({1'b0, sram_rdata} >= r_npix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ro  <= 1'b0;
            r_oob <= 1'b0;
        end else begin
            r_ro <= w_oob;
            if (w_idle && start) r_oob <= 1'b0;
            else if (w_oob) r_oob <= 1'b1;
        end
    end

    assign oob_err = r_oob;
    assign w_fdata = r_ro ? FILL : r_rdat;
`else
    assign w_fdata = r_rdat;
`endif

    remap_out_fifo #(
        .DEPTH (OFIFO_DEPTH),
        .W     (PW + 1)
    ) u_ofifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (r_rv),
        .i_wdata ({r_rl, w_fdata}),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_fcnt)
    );

    assign frm_ready  = w_idle;
    assign lut_ready  = w_idle;
    assign busy       = !w_idle;
    assign done       = r_done;
    assign m_valid    = !w_empty;
    assign m_data     = w_head[PW-1:0];
    assign m_last     = w_head[PW] & !w_empty;
    assign sram_addr  = r_sram_addr;
    assign sram_we_n  = r_sram_we_n;
    assign sram_wdata = r_sram_wd;

endmodule

// File: tb/tb_lut_remap_engine.sv
// tb_lut_remap_engine: two engines (SRAM latency 1 and 4) share stimulus; outputs checked
// against scoreboard queues filled when each remap is started.
module tb_lut_remap_engine;

    localparam int AW = 8;
    localparam logic [7:0] FILL_V = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW:0]   cfg_npix = '0;
    logic          frm_valid = 1'b0;
    logic [7:0]    frm_data = '0;
    logic          lut_valid = 1'b0;
    logic [AW-1:0] lut_data = '0;
    logic          start = 1'b0;
    logic          m_ready = 1'b1;

    logic fr1, lr1, busy1, done1, mv1, ml1, we1;
    logic fr4, lr4, busy4, done4, mv4, ml4, we4;
    logic [7:0] md1, md4;
    logic [AW-1:0] sa1, sw1, rd1, sa4, sw4, rd4;
    logic oob1, oob4;

    lut_remap_engine #(
        .PIX_W(8), .CH(1), .ADDR_W(AW), .SRAM_RD_LAT(1), .OFIFO_DEPTH(8)
`ifdef REMAP_OOB_EN
        , .FILL(FILL_V)
`endif
    ) u_d1 (
        .clk(clk), .rst(rst), .cfg_npix(cfg_npix),
        .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(fr1),
        .lut_valid(lut_valid), .lut_data(lut_data), .lut_ready(lr1),
        .start(start), .busy(busy1), .done(done1),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_last(ml1),
        .sram_addr(sa1), .sram_we_n(we1), .sram_wdata(sw1), .sram_rdata(rd1)
`ifdef REMAP_OOB_EN
        , .oob_err(oob1)
`endif
    );

    lut_remap_engine #(
        .PIX_W(8), .CH(1), .ADDR_W(AW), .SRAM_RD_LAT(4), .OFIFO_DEPTH(8)
`ifdef REMAP_OOB_EN
        , .FILL(FILL_V)
`endif
    ) u_d4 (
        .clk(clk), .rst(rst), .cfg_npix(cfg_npix),
        .frm_valid(frm_valid), .frm_data(frm_data), .frm_ready(fr4),
        .lut_valid(lut_valid), .lut_data(lut_data), .lut_ready(lr4),
        .start(start), .busy(busy4), .done(done4),
        .m_valid(mv4), .m_ready(m_ready), .m_data(md4), .m_last(ml4),
        .sram_addr(sa4), .sram_we_n(we4), .sram_wdata(sw4), .sram_rdata(rd4)
`ifdef REMAP_OOB_EN
        , .oob_err(oob4)
`endif
    );

`ifndef REMAP_OOB_EN
    assign oob1 = 1'b0;
    assign oob4 = 1'b0;
`endif

    // SRAM models: read data appears SRAM_RD_LAT edges after the address is sampled
    logic [AW-1:0] mem1 [256];
    logic [AW-1:0] mem4 [256];
    logic [AW-1:0] p1;
    logic [AW-1:0] p4 [4];

    always @(posedge clk) begin
        if (!we1) mem1[sa1] <= sw1;
        p1 <= mem1[sa1];
        if (!we4) mem4[sa4] <= sw4;
        p4[0] <= mem4[sa4];
        for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
    end
    assign rd1 = p1;
    assign rd4 = p4[3];

    int tot = 0;
    int bad = 0;
    int cyc = 0;
    int pops1 = 0;
    int dones1 = 0;
    int last_cyc = 0;
    logic [8:0] q1[$];
    logic [8:0] q4[$];
    logic [8:0] h1, h4;
    bit st1 = 1'b0;
    bit st4 = 1'b0;
    logic [7:0] fm [256];
    logic [7:0] lm [256];
    logic [7:0] frm_m [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (done1) dones1++;
            if (mv1 && m_ready) begin
                chk("q1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) chk("d1_pixel", {ml1, md1}, q1.pop_front());
                pops1++;
                if (ml1) last_cyc = cyc;
            end
            if (mv4 && m_ready) begin
                chk("q4_nonempty", q4.size() > 0, 1);
                if (q4.size() > 0) chk("d4_pixel", {ml4, md4}, q4.pop_front());
            end
            if (mv1 && !m_ready) begin
                if (st1) chk("d1_stall_hold", {ml1, md1}, h1);
                h1 = {ml1, md1};
                st1 = 1'b1;
            end else st1 = 1'b0;
            if (mv4 && !m_ready) begin
                if (st4) chk("d4_stall_hold", {ml4, md4}, h4);
                h4 = {ml4, md4};
                st4 = 1'b1;
            end else st4 = 1'b0;
        end
    end

    task automatic load(input int n);
        cfg_npix = (AW+1)'(n);
        for (int i = 0; i < n; i++) begin
            frm_valid = 1'b1;
            frm_data  = fm[i];
            lut_valid = 1'b1;
            lut_data  = lm[i];
            frm_m[i]  = fm[i];
            @(posedge clk);
            #1;
        end
        frm_valid = 1'b0;
        lut_valid = 1'b0;
    endtask

    task automatic push(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = (int'(lm[i]) >= n) ? FILL_V : frm_m[lm[i]];
            q1.push_back({1'(i == n - 1), e});
            q4.push_back({1'(i == n - 1), e});
        end
    endtask

    task automatic run(input int n, input bit rnd, input bit dbl);
        int lat1, lat4, k, done_cyc, done_k;
        bit seen;
        pops1 = 0;
        dones1 = 0;
        push(n);
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat1 = -1;
        lat4 = -1;
        seen = 1'b0;
        done_cyc = 0;
        done_k = 0;
        k = 0;
        while (k < 2000 && !(seen && !busy4)) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (dbl && k == 3);
            @(posedge clk);
            #1;
            k++;
            if (mv1 && lat1 < 0) lat1 = k;
            if (mv4 && lat4 < 0) lat4 = k;
            if (done1 && !seen) begin
                seen = 1'b1;
                done_cyc = cyc;
                done_k = k;
            end
        end
        start = 1'b0;
        m_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", seen, 1);
        if (n > 0) chk("done_after_last", done_cyc, last_cyc + 1);
        else chk("npix0_done_next", done_k, 1);
        if (!rnd && n > 0) begin
            chk("latency_lat1", lat1, 4);
            chk("latency_lat4", lat4, 7);
        end
        chk("pop_count", pops1, n);
        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("single_done", dones1, 1);
        chk("idle_after", busy1, 0);
    endtask

    initial begin
        int k;
        #2 rst = 1'b1;
        #1;
        chk("rst_frm_ready", fr1, 1);
        chk("rst_lut_ready", lr1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_m_valid", mv1, 0);
        chk("rst_m_last", ml1, 0);
        chk("rst_we_n", we1, 1);
        chk("rst_addr", sa1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // reversed frame, fixed backpressure-free stream, latency of both engines
        for (int i = 0; i < 16; i++) begin
            fm[i] = 8'(i);
            lm[i] = 8'(15 - i);
        end
        load(16);
        run(16, 1'b0, 1'b0);

        // random data and LUT, random m_ready, extra start while busy
        for (int i = 0; i < 16; i++) begin
            fm[i] = 8'($urandom);
            lm[i] = 8'($urandom_range(0, 15));
        end
        load(16);
        run(16, 1'b1, 1'b1);

        // reset in the middle of a remap
        for (int i = 0; i < 16; i++) begin
            fm[i] = 8'($urandom);
            lm[i] = 8'($urandom_range(0, 15));
        end
        load(16);
        push(16);
        pops1 = 0;
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (pops1 < 5 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_pops", pops1, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", mv1, 0);
        chk("mid_rst_m_last", ml1, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_ready", {fr1, lr1}, 2'b11);
        chk("mid_rst_we_n", we1, 1);
        chk("mid_rst_addr", sa1, 0);
        chk("mid_rst_busy4", busy4, 0);
        q1.delete();
        q4.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_done", done1, 0);
        for (int i = 0; i < 12; i++) begin
            fm[i] = 8'($urandom);
            lm[i] = 8'($urandom_range(0, 11));
        end
        load(12);
        run(12, 1'b0, 1'b0);

        // empty frame
        cfg_npix = '0;
        run(0, 1'b0, 1'b0);

`ifdef REMAP_OOB_EN
        for (int i = 0; i < 8; i++) begin
            fm[i] = 8'(8'h40 + i);
            lm[i] = 8'(i);
        end
        lm[3] = 8'd9;
        load(8);
        run(8, 1'b0, 1'b0);
        chk("oob_set_d1", oob1, 1);
        chk("oob_set_d4", oob4, 1);
        cfg_npix = '0;
        run(0, 1'b0, 1'b0);
        chk("oob_clear_d1", oob1, 0);
`endif

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
